// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller. Picks the lowest-index enabled request,
// raises a one-cycle interrupt to the core, holds the cause code until mret,
// then acknowledges the served source and blocks for one guard cycle.
module irq_controller #(
   parameter int          IRQ_NUM    = 16,
   parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [IRQ_NUM-1:0] irq_req_i,
   input  logic [IRQ_NUM-1:0] mie_i,
   input  logic               irq_ret_i,
   output logic               irq_o,
   output logic [31:0]        irq_cause_o,
   output logic [IRQ_NUM-1:0] irq_ack_o,
   output logic               busy_o
);

   localparam int IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      GUARD = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx_q;
   logic [IRQ_NUM-1:0] masked;
   logic               masked_any;
   logic [IDX_W-1:0]   enc_idx;
   logic [IRQ_NUM-1:0] ack_onehot;

   assign masked     = irq_req_i & mie_i;
   assign masked_any = |masked;

   // Priority encoder: lowest set index wins (scan high to low, last hit sticks)
   always_comb begin
      enc_idx = '0;
      for (int i = IRQ_NUM - 1; i >= 0; i--) begin
         if (masked[i]) enc_idx = IDX_W'(i);
      end
   end

   // One-hot decode of the served index for the acknowledge pulse
   always_comb begin
      ack_onehot = '0;
      for (int i = 0; i < IRQ_NUM; i++) begin
         ack_onehot[i] = (idx_q == IDX_W'(i));
      end
   end

   // Control FSM with all outputs registered
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         idx_q       <= '0;
         irq_o       <= 1'b0;
         irq_cause_o <= '0;
         irq_ack_o   <= '0;
         busy_o      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               irq_ack_o <= '0;
               if (masked_any) begin
                  idx_q       <= enc_idx;
                  irq_o       <= 1'b1;
                  irq_cause_o <= CAUSE_BASE + {{(32 - IDX_W){1'b0}}, enc_idx};
                  busy_o      <= 1'b1;
                  state       <= SERVE;
               end else begin
                  irq_o       <= 1'b0;
                  irq_cause_o <= '0;
                  busy_o      <= 1'b0;
               end
            end
            SERVE: begin
               // Request/mask changes are ignored here; only mret moves us on.
               irq_o <= 1'b0;
               if (irq_ret_i) begin
                  irq_ack_o <= ack_onehot;
                  state     <= GUARD;
               end
            end
            GUARD: begin
               // One cycle for the peripheral to drop its level before resampling.
               irq_o       <= 1'b0;
               irq_ack_o   <= '0;
               irq_cause_o <= '0;
               busy_o      <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               irq_o       <= 1'b0;
               irq_ack_o   <= '0;
               irq_cause_o <= '0;
               busy_o      <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
